// File: rtl/ps2_pkg.sv
// Shared PS/2 host-side constants and the LED command sequencer state type.
package ps2_pkg;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_ACK         = 8'hFA;
    localparam logic [7:0] PS2_RESEND      = 8'hFE;
    localparam logic [7:0] PS2_SC_CAPS     = 8'h58;
    localparam logic [7:0] PS2_SC_NUM      = 8'h77;
    localparam logic [7:0] PS2_SC_SCROLL   = 8'h7E;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ACK1,
        LED,
        ACK2
    } t_led_seq_state;

endpackage

// File: rtl/ps2_led_sequencer_if.sv
// Signal bundle between the LED sequencer and its keyboard decoder, TX driver and application.
interface ps2_led_sequencer_if;

    logic        i_press;
    logic        i_release;
    logic [15:0] i_key;
    logic        i_emp;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        i_tx_ready;
    logic        i_tx_err;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic [2:0]  o_leds;
    logic        o_busy;
    logic        o_err;

    modport slave (
        input  i_press, i_release, i_key, i_emp, i_rx_valid, i_rx_data, i_tx_ready, i_tx_err,
        output o_tx_valid, o_tx_data, o_leds, o_busy, o_err
    );

    modport master (
        output i_press, i_release, i_key, i_emp, i_rx_valid, i_rx_data, i_tx_ready, i_tx_err,
        input  o_tx_valid, o_tx_data, o_leds, o_busy, o_err
    );

endinterface

// File: rtl/ps2_lock_tracker.sv
// Lock-key decode with typematic suppression; owns the lock state and the "needs sending" flag.
module ps2_lock_tracker
    import ps2_pkg::*;
#(
    parameter logic [2:0] p_leds_init = 3'b010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_press,
    input  logic        key_release,
    input  logic [15:0] key,
    input  logic        emp,
    input  logic        launch,
    output logic [2:0]  leds,
    output logic        pending
);

    logic       key_ok;
    logic [2:0] hit;
    logic [2:0] held;
    logic [2:0] held_nxt;
    logic [2:0] toggle;

    always_comb begin
        key_ok = !emp && (key[15:8] == 8'h00);
        hit    = {key[7:0] == PS2_SC_CAPS,
                  key[7:0] == PS2_SC_NUM,
                  key[7:0] == PS2_SC_SCROLL} & {3{key_ok}};
        toggle   = key_press ? (hit & ~held) : 3'b000;
        held_nxt = (held | (key_press ? hit : 3'b000)) & ~(key_release ? hit : 3'b000);
    end

    // A toggle in the launch cycle wins over the clear so its new state is sent too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds    <= p_leds_init;
            held    <= 3'b000;
            pending <= 1'b1;
        end else begin
            leds <= leds ^ toggle;
            held <= held_nxt;
            if (|toggle) begin
                pending <= 1'b1;
            end else if (launch) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ps2_led_sequencer.sv
// Sends "Set LEDs" (0xED + LED byte) to the keyboard whenever lock state changes,
// with per-byte ACK check, response timeout and bounded retries.
module ps2_led_sequencer
    import ps2_pkg::*;
#(
    parameter int         p_timeout   = 1000000,
    parameter int         p_retry     = 3,
    parameter logic [2:0] p_leds_init = 3'b010
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    ps2_led_sequencer_if.slave  bus
);

    localparam int TW = $clog2(p_timeout + 1);

    t_led_seq_state state, state_nxt;
    logic [3:0]     attempt, attempt_nxt;
    logic [TW-1:0]  timer, timer_nxt;
    logic [2:0]     led_snap, led_snap_nxt;
    logic           tx_valid, tx_valid_nxt;
    logic [7:0]     tx_data, tx_data_nxt;
    logic           err, err_nxt;
    logic           launch;
    logic           pending;
    logic [2:0]     leds;
    logic           accept;
    logic           timeout;
    logic           ack_ev;
    logic           fail_ev;

    ps2_lock_tracker #(
        .p_leds_init (p_leds_init)
    ) u_lock_tracker (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .key_press   (bus.i_press),
        .key_release (bus.i_release),
        .key         (bus.i_key),
        .emp         (bus.i_emp),
        .launch      (launch),
        .leds        (leds),
        .pending     (pending)
    );

    // TX error beats a same-cycle received byte; any received byte beats the timeout.
    always_comb begin
        accept  = tx_valid && bus.i_tx_ready;
        timeout = (timer == TW'(p_timeout));
        ack_ev  = !bus.i_tx_err && bus.i_rx_valid && (bus.i_rx_data == PS2_ACK);
        fail_ev = bus.i_tx_err
                  || (bus.i_rx_valid && (bus.i_rx_data == PS2_RESEND))
                  || (!bus.i_rx_valid && timeout);
    end

    always_comb begin
        state_nxt    = state;
        attempt_nxt  = attempt;
        timer_nxt    = timer;
        led_snap_nxt = led_snap;
        tx_valid_nxt = tx_valid;
        tx_data_nxt  = tx_data;
        err_nxt      = 1'b0;
        launch       = 1'b0;

        case (state)
            IDLE: begin
                if (pending) begin
                    launch       = 1'b1;
                    led_snap_nxt = leds;
                    attempt_nxt  = 4'd1;
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = PS2_CMD_SET_LED;
                    state_nxt    = CMD;
                end
            end

            CMD, LED: begin
                if (accept) begin
                    tx_valid_nxt = 1'b0;
                    timer_nxt    = '0;
                    state_nxt    = (state == CMD) ? ACK1 : ACK2;
                end
            end

            ACK1, ACK2: begin
                timer_nxt = timeout ? timer : timer + TW'(1);
                if (ack_ev) begin
                    if (state == ACK1) begin
                        tx_valid_nxt = 1'b1;
                        tx_data_nxt  = {5'b00000, led_snap};
                        attempt_nxt  = 4'd1;
                        state_nxt    = LED;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (fail_ev) begin
                    // tx_data still holds the byte just sent, so a retry re-offers it unchanged.
                    if (attempt < 4'(p_retry)) begin
                        attempt_nxt  = attempt + 4'd1;
                        tx_valid_nxt = 1'b1;
                        state_nxt    = (state == ACK1) ? CMD : LED;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            attempt  <= 4'd0;
            timer    <= '0;
            led_snap <= 3'b000;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            attempt  <= attempt_nxt;
            timer    <= timer_nxt;
            led_snap <= led_snap_nxt;
            tx_valid <= tx_valid_nxt;
            tx_data  <= tx_data_nxt;
            err      <= err_nxt;
        end
    end

    assign bus.o_tx_valid = tx_valid;
    assign bus.o_tx_data  = tx_data;
    assign bus.o_leds     = leds;
    assign bus.o_busy     = (state != IDLE);
    assign bus.o_err      = err;

endmodule

// File: tb/tb_ps2_led_sequencer.sv
// Self-checking bench: lock-key vector table plus hand-written retry, timeout and reset sequences.
module tb_ps2_led_sequencer;

    localparam int TMO = 100;
    localparam int RTY = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   err_cnt;
    bit   acc;
    logic [7:0] sb[$];

    ps2_led_sequencer_if bus();

    ps2_led_sequencer #(
        .p_timeout   (TMO),
        .p_retry     (RTY),
        .p_leds_init (3'b010)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] key;
        logic        emp;
        int          presses;
        logic [2:0]  leds;
        logic        seq;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Samples outputs mid-cycle, scores any byte accepted at the coming edge, then advances.
    task automatic step();
        logic [7:0] e;
        if (bus.o_err === 1'b1) err_cnt++;
        acc = 1'b0;
        if (bus.o_tx_valid === 1'b1 && bus.i_tx_ready === 1'b1) begin
            acc = 1'b1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_byte unexpected byte got %02h expected none", bus.o_tx_data);
            end else begin
                e = sb.pop_front();
                check("tx_byte", 32'(bus.o_tx_data), 32'(e));
            end
        end
        @(negedge clk);
        bus.i_press    = 1'b0;
        bus.i_release  = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_tx_err   = 1'b0;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc && n < 400);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL wait_accept no byte accepted within %0d cycles expected one", n);
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (bus.o_tx_valid !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check("wait_valid", 32'(bus.o_tx_valid), 32'd1);
    endtask

    task automatic respond(input logic [7:0] b, input logic with_err);
        repeat (2) step();
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        bus.i_tx_err   = with_err;
        step();
    endtask

    task automatic press_key(input logic [15:0] k, input logic e);
        bus.i_key   = k;
        bus.i_emp   = e;
        bus.i_press = 1'b1;
        step();
    endtask

    task automatic release_key(input logic [15:0] k);
        bus.i_key     = k;
        bus.i_emp     = 1'b0;
        bus.i_release = 1'b1;
        step();
    endtask

    task automatic run_seq(input logic [2:0] led);
        sb.push_back(8'hED);
        sb.push_back({5'b00000, led});
        bus.i_tx_ready = 1'b1;
        wait_accept();
        respond(8'hFA, 1'b0);
        wait_accept();
        respond(8'hFA, 1'b0);
        repeat (3) step();
        check("idle_after_seq", 32'(bus.o_busy), 32'd0);
    endtask

    initial begin
        int base_err;
        int n;
        checks  = 0;
        errors  = 0;
        err_cnt = 0;

        vecs[0] = '{16'h0058, 1'b0, 3, 3'b110, 1'b1};
        vecs[1] = '{16'h0077, 1'b0, 1, 3'b100, 1'b1};
        vecs[2] = '{16'h007E, 1'b0, 2, 3'b101, 1'b1};
        vecs[3] = '{16'h0058, 1'b1, 1, 3'b101, 1'b0};
        vecs[4] = '{16'hE058, 1'b0, 1, 3'b101, 1'b0};
        vecs[5] = '{16'h001C, 1'b0, 1, 3'b101, 1'b0};
        vecs[6] = '{16'h0058, 1'b0, 1, 3'b001, 1'b1};
        vecs[7] = '{16'h0077, 1'b0, 1, 3'b011, 1'b1};

        rst_n          = 1'b0;
        bus.i_press    = 1'b0;
        bus.i_release  = 1'b0;
        bus.i_key      = 16'h0000;
        bus.i_emp      = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_tx_ready = 1'b0;
        bus.i_tx_err   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_leds", 32'(bus.o_leds), 32'(3'b010));
        check("rst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.o_tx_data), 32'h00);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_err", 32'(bus.o_err), 32'd0);

        // Initial state is sent right after reset; TX stalled to observe the hold.
        rst_n = 1'b1;
        step();
        check("post_rst_valid", 32'(bus.o_tx_valid), 32'd1);
        check("post_rst_data", 32'(bus.o_tx_data), 32'hED);
        check("post_rst_busy", 32'(bus.o_busy), 32'd1);
        repeat (3) step();
        check("hold_valid", 32'(bus.o_tx_valid), 32'd1);
        check("hold_data", 32'(bus.o_tx_data), 32'hED);
        run_seq(3'b010);
        check("post_rst_leds", 32'(bus.o_leds), 32'(3'b010));
        check("post_rst_no_err", 32'(err_cnt), 32'd0);

        for (int i = 0; i < 8; i++) begin
            bus.i_tx_ready = 1'b0;
            press_key(vecs[i].key, vecs[i].emp);
            check("vec_leds_first", 32'(bus.o_leds), 32'(vecs[i].leds));
            for (int r = 1; r < vecs[i].presses; r++) begin
                step();
                press_key(vecs[i].key, vecs[i].emp);
            end
            check("vec_leds_repeat", 32'(bus.o_leds), 32'(vecs[i].leds));
            release_key(vecs[i].key);
            if (vecs[i].seq) begin
                check("vec_offer", {31'd0, bus.o_tx_valid}, 32'd1);
                run_seq(vecs[i].leds);
            end else begin
                repeat (10) step();
                check("vec_no_seq_busy", 32'(bus.o_busy), 32'd0);
                check("vec_no_seq_valid", 32'(bus.o_tx_valid), 32'd0);
            end
        end

        // Resend on 0xED, then TX error (colliding with an ACK) on the LED byte.
        press_key(16'h0058, 1'b0);
        release_key(16'h0058);
        sb.push_back(8'hED);
        sb.push_back(8'hED);
        sb.push_back(8'h07);
        sb.push_back(8'h07);
        bus.i_tx_ready = 1'b1;
        wait_accept();
        respond(8'hFE, 1'b0);
        wait_accept();
        respond(8'hFA, 1'b0);
        wait_accept();
        respond(8'hFA, 1'b1);
        wait_accept();
        respond(8'hFA, 1'b0);
        repeat (3) step();
        check("retry_idle", 32'(bus.o_busy), 32'd0);
        check("retry_no_err", 32'(err_cnt), 32'd0);
        check("retry_leds", 32'(bus.o_leds), 32'(3'b111));

        // Silent device: three timed-out attempts then one error pulse.
        press_key(16'h0077, 1'b0);
        release_key(16'h0077);
        sb.push_back(8'hED);
        sb.push_back(8'hED);
        sb.push_back(8'hED);
        base_err = err_cnt;
        for (int a = 0; a < 2; a++) begin
            wait_accept();
            n = 0;
            while (bus.o_tx_valid !== 1'b1 && n < 500) begin
                step();
                n++;
            end
            // Count reaches TMO one cycle before the registered re-offer appears.
            check("timeout_gap", 32'(n), 32'(TMO + 1));
        end
        wait_accept();
        repeat (TMO + 20) step();
        check("timeout_err_pulses", 32'(err_cnt - base_err), 32'd1);
        check("timeout_busy", 32'(bus.o_busy), 32'd0);
        check("timeout_valid", 32'(bus.o_tx_valid), 32'd0);
        check("timeout_sb_empty", 32'(sb.size()), 32'd0);

        // Num toggled while the Caps LED byte is on the bus.
        press_key(16'h0058, 1'b0);
        release_key(16'h0058);
        sb.push_back(8'hED);
        sb.push_back(8'h01);
        wait_accept();
        respond(8'hFA, 1'b0);
        bus.i_tx_ready = 1'b0;
        wait_valid();
        press_key(16'h0077, 1'b0);
        release_key(16'h0077);
        repeat (2) step();
        check("midseq_led_byte", 32'(bus.o_tx_data), 32'h01);
        check("midseq_leds", 32'(bus.o_leds), 32'(3'b011));
        sb.push_back(8'hED);
        sb.push_back(8'h03);
        bus.i_tx_ready = 1'b1;
        wait_accept();
        respond(8'hFA, 1'b0);
        wait_accept();
        respond(8'hFA, 1'b0);
        wait_accept();
        respond(8'hFA, 1'b0);
        repeat (3) step();
        check("midseq_idle", 32'(bus.o_busy), 32'd0);

        // Second toggle lands on the launch cycle: two sequences with old then new state.
        sb.push_back(8'hED);
        sb.push_back(8'h07);
        sb.push_back(8'hED);
        sb.push_back(8'h05);
        press_key(16'h0058, 1'b0);
        press_key(16'h0077, 1'b0);
        for (int s = 0; s < 4; s++) begin
            wait_accept();
            respond(8'hFA, 1'b0);
        end
        release_key(16'h0058);
        release_key(16'h0077);
        repeat (3) step();
        check("collide_idle", 32'(bus.o_busy), 32'd0);
        check("collide_leds", 32'(bus.o_leds), 32'(3'b101));

        // Asynchronous reset while the LED byte is being offered.
        press_key(16'h007E, 1'b0);
        release_key(16'h007E);
        sb.push_back(8'hED);
        sb.push_back(8'h04);
        wait_accept();
        respond(8'hFA, 1'b0);
        bus.i_tx_ready = 1'b0;
        wait_valid();
        check("pre_rst_data", 32'(bus.o_tx_data), 32'h04);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.o_tx_valid), 32'd0);
        check("async_rst_data", 32'(bus.o_tx_data), 32'h00);
        check("async_rst_busy", 32'(bus.o_busy), 32'd0);
        check("async_rst_leds", 32'(bus.o_leds), 32'(3'b010));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(3'b010);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("final_no_err", 32'(err_cnt - base_err), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
